// File: rtl/kernel_cc_start_fifo_gen.sv
// ---------------------------------------------------------------------------
// kernel_cc_start_fifo_gen
// Parametrised shift-register handshake FIFO for HLS dataflow start/token
// channels between kernel_cc processes.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               synchronous flush, discards all entries, clears errors
//   if_write/_ce/if_din producer side; write effective on if_write & if_write_ce
//   if_full_n           1 = space available (registered)
//   if_read/_ce         consumer side; read effective on if_read & if_read_ce
//   if_dout             head-of-queue data (combinational from storage)
//   if_empty_n          1 = data available (registered)
//   if_count            occupancy 0..DEPTH (registered)
//   almost_full/empty   programmable threshold flags (registered)
//   err_overflow/_under sticky protocol-error flags, cleared by reset/flush
// ---------------------------------------------------------------------------
module kernel_cc_start_fifo_gen #(
   parameter int DATA_WIDTH    = 1,
   parameter int DEPTH         = 4,
   parameter int ADDR_WIDTH    = 2,
   parameter int AFULL_THRESH  = DEPTH - 1,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  if_write,
   input  logic                  if_write_ce,
   input  logic [DATA_WIDTH-1:0] if_din,
   output logic                  if_full_n,
   input  logic                  if_read,
   input  logic                  if_read_ce,
   output logic [DATA_WIDTH-1:0] if_dout,
   output logic                  if_empty_n,
   output logic [ADDR_WIDTH:0]   if_count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  err_overflow,
   output logic                  err_underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];

   // ptr_r holds count-1; all-ones (MSB set) encodes "empty"
   logic [ADDR_WIDTH:0] ptr_r, ptr_next_s;
   logic [ADDR_WIDTH:0] count_r, count_next_s;
   logic empty_n_r, full_n_r, afull_r, aempty_r, ovf_r, unf_r;
   logic ovf_next_s, unf_next_s;
   logic wr_req_s, rd_req_s, wr_acc_s, rd_acc_s;
   logic [DATA_WIDTH-1:0] dout_s;

   assign wr_req_s = if_write & if_write_ce;
   assign rd_req_s = if_read & if_read_ce;
   assign wr_acc_s = wr_req_s & full_n_r;
   assign rd_acc_s = rd_req_s & empty_n_r;

   // Next occupancy, pointer and sticky error state; flush overrides traffic
   always_comb begin
      count_next_s = count_r;
      ptr_next_s   = ptr_r;
      ovf_next_s   = ovf_r | (wr_req_s & ~full_n_r);
      unf_next_s   = unf_r | (rd_req_s & ~empty_n_r);
      if (flush) begin
         count_next_s = '0;
         ptr_next_s   = '1;
         ovf_next_s   = 1'b0;
         unf_next_s   = 1'b0;
      end else begin
         case ({wr_acc_s, rd_acc_s})
            2'b10: begin
               count_next_s = count_r + ONE_C;
               ptr_next_s   = ptr_r + ONE_C;
            end
            2'b01: begin
               count_next_s = count_r - ONE_C;
               ptr_next_s   = ptr_r - ONE_C;
            end
            // both accepted: shift-in plus pointer hold keeps the head aligned
            default: begin
               count_next_s = count_r;
               ptr_next_s   = ptr_r;
            end
         endcase
      end
   end

   // Control/status registers; status flags are precomputed from next count
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_r     <= '1;
         count_r   <= '0;
         empty_n_r <= 1'b0;
         full_n_r  <= 1'b1;
         afull_r   <= 1'b0;
         aempty_r  <= 1'b1;
         ovf_r     <= 1'b0;
         unf_r     <= 1'b0;
      end else begin
         ptr_r     <= ptr_next_s;
         count_r   <= count_next_s;
         empty_n_r <= (count_next_s != '0);
         full_n_r  <= (count_next_s != DEPTH_C);
         afull_r   <= (count_next_s >= AFULL_C);
         aempty_r  <= (count_next_s <= AEMPTY_C);
         ovf_r     <= ovf_next_s;
         unf_r     <= unf_next_s;
      end
   end

   // Data storage: shift register, newest at entry 0; contents never reset
   always_ff @(posedge clk) begin
      if (!reset && !flush && wr_acc_s) begin
         mem_r[0] <= if_din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_r[i] <= mem_r[i-1];
         end
      end
   end

   // Head-of-queue select; falls back to entry 0 when empty
   always_comb begin
      if (ptr_r[ADDR_WIDTH] == 1'b0) begin
         dout_s = mem_r[ptr_r[ADDR_WIDTH-1:0]];
      end else begin
         dout_s = mem_r[0];
      end
   end

   assign if_dout       = dout_s;
   assign if_empty_n    = empty_n_r;
   assign if_full_n     = full_n_r;
   assign if_count      = count_r;
   assign almost_full   = afull_r;
   assign almost_empty  = aempty_r;
   assign err_overflow  = ovf_r;
   assign err_underflow = unf_r;

endmodule

// File: tb/tb_kernel_cc_start_fifo_gen.sv
module tb_kernel_cc_start_fifo_gen;

   localparam int DW = 8;
   localparam int DEPTH = 4;
   localparam int AW = 2;
   localparam int AF = 3;
   localparam int AE = 1;

   logic clk = 1'b0;
   logic reset = 1'b1, flush = 1'b0;
   logic if_write = 1'b0, if_write_ce = 1'b0, if_read = 1'b0, if_read_ce = 1'b0;
   logic [DW-1:0] if_din = 8'h00;
   logic [DW-1:0] if_dout;
   logic if_full_n, if_empty_n, almost_full, almost_empty, err_overflow, err_underflow;
   logic [AW:0] if_count;

   kernel_cc_start_fifo_gen #(
      .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
      .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .if_write(if_write), .if_write_ce(if_write_ce), .if_din(if_din),
      .if_full_n(if_full_n),
      .if_read(if_read), .if_read_ce(if_read_ce), .if_dout(if_dout),
      .if_empty_n(if_empty_n), .if_count(if_count),
      .almost_full(almost_full), .almost_empty(almost_empty),
      .err_overflow(err_overflow), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit rst, fl, wr, wce, rd, rce;
      logic [7:0] din;
      int cnt;
      bit ovf, unf;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] sb[$];  // scoreboard: expected read data in order
   int npass = 0;
   int ntot = 0;

   task automatic add(input bit rst, input bit fl, input bit wr, input bit wce,
                      input bit rd, input bit rce, input logic [7:0] din,
                      input int cnt, input bit ovf, input bit unf);
      vec_t v;
      v.rst = rst; v.fl = fl; v.wr = wr; v.wce = wce; v.rd = rd; v.rce = rce;
      v.din = din; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
   endtask

   task automatic apply(input int idx, input vec_t v);
      bit wacc, racc;
      @(negedge clk);
      reset = v.rst; flush = v.fl;
      if_write = v.wr; if_write_ce = v.wce; if_din = v.din;
      if_read = v.rd; if_read_ce = v.rce;
      wacc = !v.rst && !v.fl && v.wr && v.wce && (sb.size() != DEPTH);
      racc = !v.rst && !v.fl && v.rd && v.rce && (sb.size() != 0);
      #1;
      if (racc) chk("dout", idx, int'(if_dout), int'(sb.pop_front()));
      if (wacc) sb.push_back(v.din);
      if (v.rst || v.fl) sb.delete();
      @(posedge clk);
      #1;
      chk("count", idx, int'(if_count), v.cnt);
      chk("empty_n", idx, int'(if_empty_n), int'(v.cnt != 0));
      chk("full_n", idx, int'(if_full_n), int'(v.cnt != DEPTH));
      chk("almost_full", idx, int'(almost_full), int'(v.cnt >= AF));
      chk("almost_empty", idx, int'(almost_empty), int'(v.cnt <= AE));
      chk("err_overflow", idx, int'(err_overflow), int'(v.ovf));
      chk("err_underflow", idx, int'(err_underflow), int'(v.unf));
   endtask

   initial begin
      // reset then idle
      add(1,0,0,0,0,0,8'h00, 0,0,0);
      for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,8'h00, 0,0,0);
      // fill 11..44, drain in order
      add(0,0,1,1,0,0,8'h11, 1,0,0);
      add(0,0,1,1,0,0,8'h22, 2,0,0);
      add(0,0,1,1,0,0,8'h33, 3,0,0);
      add(0,0,1,1,0,0,8'h44, 4,0,0);
      for (int i = 3; i >= 0; i--) add(0,0,0,0,1,1,8'h00, i,0,0);
      // streaming at count 2
      add(0,0,1,1,0,0,8'h50, 1,0,0);
      add(0,0,1,1,0,0,8'h51, 2,0,0);
      for (int i = 0; i < 10; i++) add(0,0,1,1,1,1,8'(8'h52 + i), 2,0,0);
      add(0,0,0,0,1,1,8'h00, 1,0,0);
      add(0,0,0,0,1,1,8'h00, 0,0,0);
      // overflow behaviour
      for (int i = 0; i < 4; i++) add(0,0,1,1,0,0,8'(8'hA0 + i), i+1,0,0);
      add(0,0,1,0,0,0,8'hEE, 4,0,0);     // no ce: no error
      add(0,0,1,1,0,0,8'hEF, 4,1,0);     // overflow, word dropped
      add(0,0,0,0,0,0,8'h00, 4,1,0);     // sticky
      for (int i = 3; i >= 0; i--) add(0,0,0,0,1,1,8'h00, i,1,0);
      add(0,0,0,0,1,1,8'h00, 0,1,1);     // underflow
      add(0,1,0,0,0,0,8'h00, 0,0,0);     // flush clears errors
      add(0,0,1,1,1,1,8'hB0, 1,0,1);     // rd+wr on empty: write only
      add(0,0,1,1,0,0,8'hB1, 2,0,1);
      add(0,0,1,1,0,0,8'hB2, 3,0,1);
      add(0,0,1,1,0,0,8'hB3, 4,0,1);
      add(0,0,1,1,1,1,8'hB4, 3,1,1);     // rd+wr on full: read only
      add(0,1,1,1,0,0,8'hC0, 0,0,0);     // flush with write: dropped
      add(0,0,1,1,0,0,8'hC1, 1,0,0);
      add(0,0,0,0,1,1,8'h00, 0,0,0);
      // reset mid-burst
      add(0,0,1,1,0,0,8'hD0, 1,0,0);
      add(0,0,1,1,0,0,8'hD1, 2,0,0);
      add(1,0,1,1,0,0,8'hD2, 0,0,0);
      add(0,0,1,1,0,0,8'hD3, 1,0,0);
      add(0,0,0,0,1,1,8'h00, 0,0,0);
      add(0,1,0,0,1,1,8'h00, 0,0,0);     // read in flush cycle: no underflow

      for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

      // multi-cycle: data order after long stream with ce toggling on read side
      for (int i = 0; i < 3; i++) apply(1000 + i, '{0,0,1,1,0,0,8'(8'h60 + i), i+1,0,0});
      apply(1003, '{0,0,1,1,1,0,8'h63, 4,0,0});    // read without ce ignored
      for (int i = 3; i >= 0; i--) apply(1004 + i, '{0,0,0,0,1,1,8'h00, i,0,0});

      @(negedge clk);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
